// File: rtl/im_loader_if.sv
// Handshake and memory-write bundle for im_loader: byte-stream input, load command,
// and the instruction-memory write port plus status flags.
interface im_loader_if;
  logic        i_start;
  logic [31:0] i_base_addr;
  logic [15:0] i_word_count;
  logic        i_in_valid;
  logic [7:0]  i_in_data;
  logic        o_in_ready;
  logic        o_im_we;
  logic [31:0] o_im_addr;
  logic [31:0] o_im_wdata;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  modport master (
    output i_start, i_base_addr, i_word_count, i_in_valid, i_in_data,
    input  o_in_ready, o_im_we, o_im_addr, o_im_wdata, o_busy, o_done, o_err
  );

  modport slave (
    input  i_start, i_base_addr, i_word_count, i_in_valid, i_in_data,
    output o_in_ready, o_im_we, o_im_addr, o_im_wdata, o_busy, o_done, o_err
  );
endinterface

// File: rtl/im_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into 32-bit words and
// writes them to consecutive word addresses, holding the CPU busy while it does so.
module im_loader #(
  parameter int SIZE = 100
) (
  input logic        clk,
  input logic        reset,
  im_loader_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;

  localparam logic [31:0] LP_SIZE = 32'(SIZE);

  logic [2:0]  r_state;
  logic [31:0] r_addr;
  logic [15:0] r_remaining;
  logic [1:0]  r_bytecnt;
  logic [31:0] r_shreg;
  logic [31:0] r_im_addr;
  logic [31:0] r_im_wdata;

  logic [31:0] w_end_word;
  logic [31:0] w_next_word;
  logic        w_unused;

  // End-of-range word index, wide enough that even the largest base address cannot wrap.
  assign w_end_word  = {2'b00, bus.i_base_addr[31:2]} + {16'h0000, bus.i_word_count};
  assign w_next_word = {r_shreg[23:0], bus.i_in_data};
  assign w_unused    = &{1'b0, bus.i_base_addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= 32'h0;
      r_remaining <= 16'h0;
      r_bytecnt   <= 2'd0;
      r_shreg     <= 32'h0;
      r_im_addr   <= 32'h0;
      r_im_wdata  <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_addr      <= {bus.i_base_addr[31:2], 2'b00};
            r_remaining <= bus.i_word_count;
            r_bytecnt   <= 2'd0;
            if (bus.i_word_count == 16'h0000) begin
              r_state <= DONE;
            end else if (w_end_word > LP_SIZE) begin
              r_state <= ERR;
            end else begin
              r_state <= LOAD;
            end
          end
        end
        LOAD: begin
          // The write port registers capture the finished word so they hold it after WRITE.
          if (bus.i_in_valid) begin
            r_shreg   <= w_next_word;
            r_bytecnt <= r_bytecnt + 2'd1;
            if (r_bytecnt == 2'd3) begin
              r_im_addr  <= r_addr;
              r_im_wdata <= w_next_word;
              r_state    <= WRITE;
            end
          end
        end
        WRITE: begin
          r_addr      <= r_addr + 32'd4;
          r_remaining <= r_remaining - 16'd1;
          r_bytecnt   <= 2'd0;
          r_state     <= (r_remaining == 16'd1) ? DONE : LOAD;
        end
        DONE:    r_state <= IDLE;
        ERR:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_in_ready = (r_state == LOAD);
  assign bus.o_im_we    = (r_state == WRITE);
  assign bus.o_im_addr  = r_im_addr;
  assign bus.o_im_wdata = r_im_wdata;
  assign bus.o_busy     = (r_state == LOAD) || (r_state == WRITE) || (r_state == DONE);
  assign bus.o_done     = (r_state == DONE);
  assign bus.o_err      = (r_state == ERR);

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: a reference model queues expected writes and
// completion events, and an independent monitor checks them as the DUT emits them.
module tb_im_loader;

  localparam int SIZE = 100;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          first;
  } wr_t;

  typedef struct {
    int kind;
    bit hasWrites;
  } ev_t;

  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  logic clk;
  logic reset;
  im_loader_if bus ();

  im_loader #(.SIZE(SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int nCompared   = 0;
  int nMismatched = 0;

  wr_t wq[$];
  ev_t eq[$];
  logic [7:0] stimBytes[$];

  int startCycle     = 0;
  int lastWriteCycle = 0;
  bit fullRate       = 1'b0;
  bit monEnable      = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes or signals completion.
  always @(negedge clk) begin
    if (!reset && monEnable) begin
      if (bus.o_im_we) begin
        if (wq.size() == 0) begin
          nCompared++;
          nMismatched++;
          $display("[TB] FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write",
                   bus.o_im_addr, bus.o_im_wdata);
        end else begin
          wr_t w;
          w = wq.pop_front();
          checkOutput("write_addr", bus.o_im_addr, w.addr);
          checkOutput("write_data", bus.o_im_wdata, w.data);
          checkOutput("ready_in_write", 32'(bus.o_in_ready), 32'd0);
          if (!w.first && fullRate)
            checkOutput("write_gap", 32'(cycle - lastWriteCycle), 32'd5);
          lastWriteCycle = cycle;
        end
      end
      if (bus.o_done || bus.o_err) begin
        if (eq.size() == 0) begin
          nCompared++;
          nMismatched++;
          $display("[TB] FAIL unexpected_event: got done=%0b err=%0b, expected none",
                   bus.o_done, bus.o_err);
        end else begin
          ev_t e;
          e = eq.pop_front();
          checkOutput("event_kind", {30'h0, bus.o_err, bus.o_done}, 32'(e.kind));
          checkOutput("event_timing",
                      32'(cycle - (e.hasWrites ? lastWriteCycle : startCycle)), 32'd1);
          checkOutput("event_busy", 32'(bus.o_busy), (e.kind == EV_DONE) ? 32'd1 : 32'd0);
          checkOutput("event_ready", 32'(bus.o_in_ready), 32'd0);
        end
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(bus.o_in_ready), 32'd0);
    checkOutput({tag, "_im_we"},    32'(bus.o_im_we),    32'd0);
    checkOutput({tag, "_im_addr"},  bus.o_im_addr,       32'd0);
    checkOutput({tag, "_im_wdata"}, bus.o_im_wdata,      32'd0);
    checkOutput({tag, "_busy"},     32'(bus.o_busy),     32'd0);
    checkOutput({tag, "_done"},     32'(bus.o_done),     32'd0);
    checkOutput({tag, "_err"},      32'(bus.o_err),      32'd0);
  endtask

  // One load command: model the expected outcome, then drive start and stream bytes.
  // validMode: 0 back-to-back, 1 alternate cycles, 2 random gaps.
  task automatic applyStimulus(input logic [31:0] base, input logic [15:0] count,
                               input int validMode, input bit midStart, input int resetAfter);
    longint endWord;
    bit     legal;
    int     total;
    int     idx;
    int     budget;
    bit     toggle;
    bit     v;
    logic [31:0] alignedBase;

    alignedBase = base & 32'hFFFF_FFFC;
    endWord     = longint'(base / 4) + longint'(count);
    legal       = (count != 0) && (endWord <= SIZE);
    total       = legal ? 4 * int'(count) : 0;

    if (count == 0) begin
      eq.push_back('{kind: EV_DONE, hasWrites: 1'b0});
    end else if (!legal) begin
      eq.push_back('{kind: EV_ERR, hasWrites: 1'b0});
    end else begin
      for (int i = 0; i < int'(count); i++) begin
        wr_t w;
        w.addr  = alignedBase + 32'(4 * i);
        w.data  = {stimBytes[4*i], stimBytes[4*i+1], stimBytes[4*i+2], stimBytes[4*i+3]};
        w.first = (i == 0);
        wq.push_back(w);
      end
      eq.push_back('{kind: EV_DONE, hasWrites: 1'b1});
    end

    fullRate = (validMode == 0);
    @(negedge clk);
    bus.i_start      = 1'b1;
    bus.i_base_addr  = base;
    bus.i_word_count = count;
    startCycle       = cycle;
    @(negedge clk);
    bus.i_start      = 1'b0;
    bus.i_base_addr  = $urandom;
    bus.i_word_count = 16'($urandom);

    if (legal) begin
      checkOutput("start_ready", 32'(bus.o_in_ready), 32'd1);
      checkOutput("start_busy",  32'(bus.o_busy),     32'd1);
    end else if (count != 0) begin
      checkOutput("err_ready", 32'(bus.o_in_ready), 32'd0);
    end

    idx    = 0;
    budget = 0;
    toggle = 1'b1;
    while (idx < total && budget < 400) begin
      if (resetAfter >= 0 && idx == resetAfter) break;
      case (validMode)
        0:       v = 1'b1;
        1:       v = toggle;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      toggle = ~toggle;
      bus.i_in_valid = v;
      bus.i_in_data  = v ? stimBytes[idx] : 8'($urandom);
      bus.i_start    = midStart && (idx == 2);
      if (bus.i_start) bus.i_base_addr = alignedBase + 32'h40;
      if (v && bus.o_in_ready) idx++;
      @(negedge clk);
      budget++;
    end
    bus.i_in_valid = 1'b0;
    bus.i_start    = 1'b0;

    if (resetAfter >= 0 && idx == resetAfter) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      wq.delete();
      eq.delete();
      checkResetOutputs("midreset");
      return;
    end

    budget = 0;
    while (eq.size() != 0 && budget < 50) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (eq.size() != 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL completion_timeout: got %0d pending events, expected 0", eq.size());
      wq.delete();
      eq.delete();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end
    checkOutput("writes_pending", 32'(wq.size()), 32'd0);
    wq.delete();
    @(negedge clk);
    checkOutput("idle_busy", 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    reset            = 1'b1;
    bus.i_start      = 1'b0;
    bus.i_base_addr  = 32'h0;
    bus.i_word_count = 16'h0;
    bus.i_in_valid   = 1'b0;
    bus.i_in_data    = 8'h00;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    reset     = 1'b0;
    monEnable = 1'b1;

    stimBytes = '{8'h20, 8'h08, 8'h00, 8'h20, 8'h20, 8'h09, 8'h00, 8'h37};
    applyStimulus(32'h0, 16'd2, 0, 1'b0, -1);
    applyStimulus(32'h0, 16'd2, 1, 1'b0, -1);

    applyStimulus(32'h180, 16'd5, 0, 1'b0, -1);
    stimBytes.delete();
    for (int i = 0; i < 16; i++) stimBytes.push_back(8'($urandom));
    applyStimulus(32'h180, 16'd4, 0, 1'b0, -1);

    applyStimulus(32'h40, 16'd0, 0, 1'b0, -1);

    stimBytes.delete();
    for (int i = 0; i < 8; i++) stimBytes.push_back(8'($urandom));
    applyStimulus(32'h10, 16'd2, 0, 1'b0, 2);
    stimBytes = '{8'h08, 8'h00, 8'h00, 8'h0E};
    applyStimulus(32'h6, 16'd1, 0, 1'b0, -1);

    stimBytes.delete();
    for (int i = 0; i < 12; i++) stimBytes.push_back(8'($urandom));
    applyStimulus(32'h20, 16'd3, 0, 1'b1, -1);

    for (int n = 0; n < 20; n++) begin
      logic [15:0] cnt;
      logic [31:0] base;
      cnt  = 16'($urandom_range(0, 6));
      base = 32'($urandom_range(0, SIZE) * 4 + $urandom_range(0, 3));
      stimBytes.delete();
      for (int i = 0; i < 4 * int'(cnt); i++) stimBytes.push_back(8'($urandom));
      applyStimulus(base, cnt, $urandom_range(0, 2), ($urandom_range(0, 3) == 0), -1);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
